// File: rtl/alu_pipe.sv
// Two-stage pipelined Hack-style ALU with valid/ready handshakes and an accumulate mode.
// Optional carry/overflow flags (cy, ov) are enabled by defining ALU_EXT_FLAGS_EN.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             acc,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
`ifdef ALU_EXT_FLAGS_EN
    ,
    output logic             cy,
    output logic             ov
`endif
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic             s1_f_q, s1_no_q;
    logic [WIDTH-1:0] s1_a_d, s1_b_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, ng_q;
    logic [WIDTH-1:0] last_q;

    logic             adv1, adv2;
    logic [WIDTH-1:0] add_w, r_w;

    assign adv2 = !out_valid_q || out_ready;
    assign adv1 = !s1_valid_q || adv2;
    // An accumulate op must see the newest result in last, so it waits for an empty pipe.
    assign in_ready = adv1 && !(acc && (s1_valid_q || out_valid_q));

    always_comb begin
        s1_a_d = acc ? last_q : x;
        if (zx) s1_a_d = '0;
        if (nx) s1_a_d = ~s1_a_d;
        s1_b_d = y;
        if (zy) s1_b_d = '0;
        if (ny) s1_b_d = ~s1_b_d;
    end

`ifdef ALU_EXT_FLAGS_EN
    logic [WIDTH:0] sum_w;
    logic           cy_q, ov_q, cy_d, ov_d;

    assign sum_w = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign add_w = sum_w[WIDTH-1:0];
    assign cy_d  = s1_f_q && sum_w[WIDTH];
    assign ov_d  = s1_f_q && (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1])
                          && (sum_w[WIDTH-1] != s1_a_q[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cy_q <= 1'b0;
            ov_q <= 1'b0;
        end else if (adv2) begin
            cy_q <= cy_d;
            ov_q <= ov_d;
        end
    end

    assign cy = cy_q;
    assign ov = ov_q;
`else
    assign add_w = s1_a_q + s1_b_q;
`endif

    always_comb begin
        r_w   = s1_f_q ? add_w : (s1_a_q & s1_b_q);
        out_d = s1_no_q ? ~r_w : r_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_f_q     <= 1'b0;
            s1_no_q    <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= in_valid && in_ready;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_f_q     <= f;
            s1_no_q    <= no;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
        end else if (adv2) begin
            out_valid_q <= s1_valid_q;
            out_q       <= out_d;
            zr_q        <= (out_d == '0);
            ng_q        <= out_d[WIDTH-1];
        end
    end

    // last tracks the most recently delivered result, not the most recently computed one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (out_valid_q && out_ready) begin
            last_q <= out_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe (WIDTH = 16); extended-flag cases run when
// ALU_EXT_FLAGS_EN is defined.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0, y = '0;
    logic        acc = 1'b0;
    logic        zx = 0, nx = 0, zy = 0, ny = 0, f = 0, no = 0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out;
    logic        zr, ng;
`ifdef ALU_EXT_FLAGS_EN
    logic        cy, ov;
`endif

    always #10 clk = ~clk;

    alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .acc(acc), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .zr(zr), .ng(ng)
`ifdef ALU_EXT_FLAGS_EN
        , .cy(cy), .ov(ov)
`endif
    );

    typedef struct packed {
        logic [15:0] o;
        logic        zr;
        logic        ng;
        logic        cy;
        logic        ov;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_last = '0;
    int          total = 0;
    int          bad = 0;
    int          handoffs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] xa, input logic [15:0] yb, input logic [5:0] c);
        logic [15:0] a, b, r;
        logic [16:0] s;
        exp_t e;
        a = c[5] ? 16'h0 : xa;
        a = c[4] ? ~a : a;
        b = c[3] ? 16'h0 : yb;
        b = c[2] ? ~b : b;
        s = {1'b0, a} + {1'b0, b};
        r = c[1] ? s[15:0] : (a & b);
        e.o  = c[0] ? ~r : r;
        e.zr = (e.o == 16'h0);
        e.ng = e.o[15];
        e.cy = c[1] & s[16];
        e.ov = c[1] & (a[15] == b[15]) & (s[15] != a[15]);
        return e;
    endfunction

    task automatic drive(input logic [15:0] xv, input logic [15:0] yv, input logic accv, input logic [5:0] c);
        in_valid = 1'b1;
        x = xv; y = yv; acc = accv;
        {zx, nx, zy, ny, f, no} = c;
    endtask

    task automatic push_exp(input logic [15:0] xv, input logic [15:0] yv, input logic accv, input logic [5:0] c);
        sb.push_back(model(accv ? model_last : xv, yv, c));
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [15:0] xv, input logic [15:0] yv, input logic accv,
                        input logic [5:0] c, output int waited);
        drive(xv, yv, accv, c);
        waited = 0;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        end else begin
            push_exp(xv, yv, accv, c);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        acc = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on every handshake and checks stall stability.
    logic [17:0] prev_out;
    logic        hold_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (rst_n) begin
            if (hold_prev) chk("stable", {14'b0, ng, zr, out}, {14'b0, prev_out});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out", {16'b0, out}, {16'b0, e.o});
                    chk("zr", {31'b0, zr}, {31'b0, e.zr});
                    chk("ng", {31'b0, ng}, {31'b0, e.ng});
`ifdef ALU_EXT_FLAGS_EN
                    chk("cy", {31'b0, cy}, {31'b0, e.cy});
                    chk("ov", {31'b0, ov}, {31'b0, e.ov});
`endif
                    model_last = e.o;
                    handoffs++;
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_out  = {ng, zr, out};
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out", {16'b0, out}, 32'd0);
        chk("rst_zr", {31'b0, zr}, 32'd0);
        chk("rst_ng", {31'b0, ng}, 32'd0);
        #5 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Constants 0 and 1 with two-cycle latency.
        out_ready = 1'b1;
        send(16'h1234, 16'h0055, 1'b0, 6'b101010, w);
        idle(); #1;
        chk("lat_c1", {31'b0, out_valid}, 32'd0);
        @(negedge clk); #1;
        chk("lat_c2", {31'b0, out_valid}, 32'd1);
        chk("zero_out", {16'b0, out}, 32'd0);
        chk("zero_zr", {31'b0, zr}, 32'd1);
        @(negedge clk);
        send(16'h1234, 16'h0055, 1'b0, 6'b111111, w);
        idle(); @(negedge clk); #1;
        chk("one_out", {16'b0, out}, 32'd1);
        chk("one_zr", {31'b0, zr}, 32'd0);
        chk("one_ng", {31'b0, ng}, 32'd0);
        @(negedge clk);

        // Full throughput stream: 8, 2, 0xFFFE.
        send(16'd5, 16'd3, 1'b0, 6'b000010, w); chk("stream_w0", w, 0);
        send(16'd5, 16'd3, 1'b0, 6'b010011, w); chk("stream_w1", w, 0);
        send(16'd5, 16'd3, 1'b0, 6'b000111, w); chk("stream_w2", w, 0);
        idle(); @(negedge clk); @(negedge clk);

        // Backpressure: intake stops after two accepts, order and stability preserved.
        out_ready = 1'b0;
        drive(16'd1, 16'd0, 1'b0, 6'b000010); #1;
        chk("bp_rdy1", {31'b0, in_ready}, 32'd1);
        push_exp(16'd1, 16'd0, 1'b0, 6'b000010);
        @(negedge clk);
        drive(16'd2, 16'd0, 1'b0, 6'b000010); #1;
        chk("bp_rdy2", {31'b0, in_ready}, 32'd1);
        push_exp(16'd2, 16'd0, 1'b0, 6'b000010);
        @(negedge clk);
        drive(16'd3, 16'd0, 1'b0, 6'b000010);
        for (int i = 0; i < 3; i++) begin
            #1; chk("bp_full", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(16'd3, 16'd0, 1'b0, 6'b000010, w); chk("bp_reenable", w, 0);
        send(16'd4, 16'd0, 1'b0, 6'b000010, w);
        idle(); @(negedge clk); @(negedge clk); @(negedge clk);

        // Accumulate hazard: 5+3 then last+1.
        send(16'd5, 16'd3, 1'b0, 6'b000010, w);
        h0 = handoffs;
        send(16'hAAAA, 16'd1, 1'b1, 6'b000010, w);
        chk("acc_stall", w, 2);
        chk("acc_handoff", handoffs, h0 + 1);
        idle(); @(negedge clk); @(negedge clk); @(negedge clk);

`ifdef ALU_EXT_FLAGS_EN
        send(16'h7FFF, 16'd1, 1'b0, 6'b000010, w);
        send(16'hFFFF, 16'd1, 1'b0, 6'b000010, w);
        idle(); @(negedge clk); @(negedge clk); @(negedge clk);
`endif

        // Reset with two ops in flight; nothing stale may emerge afterwards.
        out_ready = 1'b0;
        send(16'd7, 16'd2, 1'b0, 6'b000010, w);
        send(16'd9, 16'd2, 1'b0, 6'b000010, w);
        idle();
        #5 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out", {16'b0, out}, 32'd0);
        chk("mid_rst_zr", {31'b0, zr}, 32'd0);
        sb.delete();
        model_last = '0;
        @(negedge clk);
        #5 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; chk("no_stale", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end
        // last was cleared: an acc add of 0 must give 0.
        send(16'h5555, 16'd0, 1'b1, 6'b000010, w);
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
